// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with byte lanes, wait states, ERROR responses and read-after-write forwarding.
// Define AHB_SRAM_DBG_PORT_EN to add a combinational debug read port (dbg_addr/dbg_data).
module ahb_sram_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [1:0]        htrans,
    input  logic              hready,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata
`ifdef AHB_SRAM_DBG_PORT_EN
    ,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
`endif
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_XFER, S_ERR1, S_ERR2} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx_q, acc_idx, rd_idx;
    logic [NB-1:0]     mask_q, acc_mask;
    logic              wr_q;
    logic [2:0]        cnt_q;
    logic              accept, acc_err, commit, load_rd;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       a_lo, sz_bytes, lane_bits;
    logic [DATA_W-1:0] rd_word;
    logic              unused_ok;

    assign unused_ok = ^{hburst, htrans[0], lane_bits};

    assign hreadyout = !(state == S_WAIT || state == S_ERR1);
    assign hresp     = (state == S_ERR1) || (state == S_ERR2);
    assign accept    = hsel & hready & htrans[1] & hreadyout;
    assign commit    = (state == S_XFER) && wr_q;

    // Address-phase decode: lane mask, word index and error conditions
    always_comb begin
        a_lo      = 32'(haddr[2:0]);
        sz_bytes  = 32'd1 << hsize;
        word_idx  = haddr >> OFF_W;
        acc_err   = (32'(hsize) > 32'(OFF_W))
                  || ((a_lo & (sz_bytes - 32'd1)) != 32'd0)
                  || (32'(word_idx) >= 32'(DEPTH));
        lane_bits = ((32'd1 << sz_bytes) - 32'd1) << (a_lo % 32'(NB));
        acc_mask  = lane_bits[NB-1:0];
        acc_idx   = word_idx[IDX_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:  if (cnt_q == '0) state_nxt = S_XFER;
            S_ERR1:  state_nxt = S_ERR2;
            default: begin
                if (!accept)               state_nxt = S_IDLE;
                else if (acc_err)          state_nxt = S_ERR1;
                else if (WAIT_STATES > 0)  state_nxt = S_WAIT;
                else                       state_nxt = S_XFER;
            end
        endcase
    end

    // hrdata loads on the edge entering XFER: straight from an accept with no wait
    // states, or from the last WAIT cycle using the latched index.
    assign load_rd = (accept && !acc_err && !hwrite && (WAIT_STATES == 0))
                   || (state == S_WAIT && cnt_q == '0 && !wr_q);
    assign rd_idx  = (state == S_WAIT) ? idx_q : acc_idx;

    always_comb begin
        rd_word = mem[rd_idx];
        if (commit && idx_q == rd_idx) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (mask_q[b]) rd_word[8*b +: 8] = hwdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state  <= S_IDLE;
            cnt_q  <= '0;
            idx_q  <= '0;
            mask_q <= '0;
            wr_q   <= 1'b0;
            hrdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx_q  <= acc_idx;
                mask_q <= acc_mask;
                wr_q   <= hwrite;
            end
            if (accept && WAIT_STATES > 0)
                cnt_q <= 3'(WAIT_STATES - 1);
            else if (state == S_WAIT && cnt_q != '0)
                cnt_q <= cnt_q - 3'd1;
            if (load_rd) hrdata <= rd_word;
        end
    end

    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (mask_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

`ifdef AHB_SRAM_DBG_PORT_EN
    assign dbg_data = (32'(dbg_addr) < 32'(DEPTH)) ? mem[dbg_addr] : '0;
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: one instance with 0 and one with 2 wait states.
module tb_ahb_sram_slave;
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3;

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [1:0]  trans;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        int          waits;
        logic        wresp;
        logic        resp;
        logic [31:0] rdata;
    } obs_t;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b1;
    logic        hsel0, hsel2, hwrite;
    logic [11:0] haddr;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hreadyout0, hresp0, hreadyout2, hresp2;
    logic [31:0] hrdata0, hrdata2;

    txn_t q[$];
    obs_t res[$];
    obs_t exq[$];
    int total = 0;
    int bad = 0;
    logic [31:0] mdl [2][256];
    logic [31:0] mhr [2];

    always #5 hclk = ~hclk;

    ahb_sram_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .htrans(htrans), .hready(hreadyout0),
        .hwdata(hwdata), .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
    );

    ahb_sram_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_STATES(2)) u_ws2 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .htrans(htrans), .hready(hreadyout2),
        .hwdata(hwdata), .hreadyout(hreadyout2), .hresp(hresp2), .hrdata(hrdata2)
    );

    function automatic void push(bit wr, logic [11:0] a, logic [2:0] sz, logic [1:0] tr,
                                 logic [2:0] bu, logic [31:0] d);
        txn_t t;
        t.wr = wr; t.addr = a; t.size = sz; t.trans = tr; t.burst = bu; t.data = d;
        q.push_back(t);
    endfunction

    // Reference model: sequentially consistent memory, one expectation per data phase
    function automatic void gen(int m, bit wr, logic [11:0] a, logic [2:0] sz, logic [1:0] tr,
                                logic [31:0] d);
        obs_t x;
        int   ai, bytes;
        bit   err;
        push(wr, a, sz, tr, B_SINGLE, d);
        ai = int'(a);
        x.waits = 0; x.wresp = 1'b0; x.resp = 1'b0;
        if (tr[1]) begin
            bytes = 1 << sz;
            err = (sz > 3'd2) || (ai % bytes != 0) || (ai / 4 >= 256);
            if (err) begin
                x.waits = 1; x.wresp = 1'b1; x.resp = 1'b1;
            end else begin
                x.waits = (m == 1) ? 2 : 0;
                if (wr) begin
                    for (int b = 0; b < 4; b++)
                        if (b >= ai % 4 && b < ai % 4 + bytes) mdl[m][ai/4][8*b +: 8] = d[8*b +: 8];
                end else begin
                    mhr[m] = mdl[m][ai/4];
                end
            end
        end
        x.rdata = mhr[m];
        exq.push_back(x);
    endfunction

    // Pipelined AHB master: plays q on instance m (0: no waits, 1: two waits), fills res
    task automatic run(input int m);
        int   i = 0;
        int   cyc = 0;
        bit   have_dp = 0;
        txn_t dp;
        obs_t o;
        logic rdy;
        res.delete();
        o.waits = 0; o.wresp = 1'b0; o.resp = 1'b0; o.rdata = '0;
        while (i < q.size() || have_dp) begin
            if (i < q.size()) begin
                hsel0 = (m == 0); hsel2 = (m == 1);
                haddr = q[i].addr; hwrite = q[i].wr; hsize = q[i].size;
                hburst = q[i].burst; htrans = q[i].trans;
            end else begin
                hsel0 = 1'b0; hsel2 = 1'b0; htrans = T_IDLE;
            end
            hwdata = (have_dp && dp.wr) ? dp.data : $urandom;
            @(negedge hclk);
            rdy = (m == 1) ? hreadyout2 : hreadyout0;
            if (!rdy) begin
                if (o.waits == 0) o.wresp = (m == 1) ? hresp2 : hresp0;
                o.waits++;
            end else begin
                if (have_dp) begin
                    o.resp  = (m == 1) ? hresp2 : hresp0;
                    o.rdata = (m == 1) ? hrdata2 : hrdata0;
                    res.push_back(o);
                end
                have_dp = 0;
                if (i < q.size()) begin
                    dp = q[i]; i++; have_dp = 1;
                    o.waits = 0; o.wresp = 1'b0;
                end
            end
            cyc++;
            if (cyc > 2000) begin
                total++; bad++;
                $display("FAIL run_timeout cycles=%0d required<=2000", cyc);
                break;
            end
            @(posedge hclk); #1;
        end
        hsel0 = 1'b0; hsel2 = 1'b0; htrans = T_IDLE;
        q.delete();
    endtask

    task automatic test_reset();
        hsel0 = 1'b0; hsel2 = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
        hburst = B_SINGLE; htrans = T_IDLE; hwdata = '0;
        #2 hresetn = 1'b0;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        total += 6;
        if (hreadyout0 !== 1'b1) begin bad++; $display("FAIL reset_ready0 got=%b want=1", hreadyout0); end
        if (hresp0 !== 1'b0) begin bad++; $display("FAIL reset_resp0 got=%b want=0", hresp0); end
        if (hrdata0 !== 32'h0) begin bad++; $display("FAIL reset_rdata0 got=%h want=0", hrdata0); end
        if (hreadyout2 !== 1'b1) begin bad++; $display("FAIL reset_ready2 got=%b want=1", hreadyout2); end
        if (hresp2 !== 1'b0) begin bad++; $display("FAIL reset_resp2 got=%b want=0", hresp2); end
        if (hrdata2 !== 32'h0) begin bad++; $display("FAIL reset_rdata2 got=%h want=0", hrdata2); end
        @(posedge hclk); #1;
        hresetn = 1'b1;
        mhr[0] = '0; mhr[1] = '0;
        push(1'b1, 12'h040, 3'd2, T_IDLE, B_SINGLE, 32'h1);
        push(1'b0, 12'h044, 3'd2, T_BUSY, B_SINGLE, 32'h0);
        run(0);
        for (int j = 0; j < 2; j++) begin
            total += 2;
            if (res[j].waits != 0) begin bad++; $display("FAIL idle_busy_waits[%0d] got=%0d want=0", j, res[j].waits); end
            if (res[j].resp !== 1'b0) begin bad++; $display("FAIL idle_busy_resp[%0d] got=%b want=0", j, res[j].resp); end
        end
    endtask

    task automatic test_random();
        int          r, off, w;
        bit          wr;
        logic [2:0]  sz;
        logic [1:0]  tr;
        logic [11:0] a;
        for (int m = 0; m < 2; m++) begin
            exq.delete();
            for (int k = 0; k < 16; k++) gen(m, 1'b1, 12'(k * 4), 3'd2, T_NSEQ, $urandom);
            for (int n = 0; n < 60; n++) begin
                r   = $urandom_range(0, 9);
                wr  = 1'($urandom_range(0, 1));
                sz  = 3'($urandom_range(0, 2));
                w   = $urandom_range(0, 15);
                off = $urandom_range(0, 3);
                off = off - (off % (1 << sz));
                a   = 12'(w * 4 + off);
                tr  = $urandom_range(0, 1) ? T_SEQ : T_NSEQ;
                if (r == 0) a = 12'h400 + a;
                if (r == 1) sz = 3'd3;
                if (r == 2) begin sz = 3'd2; a = 12'(w * 4 + 2); end
                if (r == 3) tr = 2'($urandom_range(0, 1));
                gen(m, wr, a, sz, tr, $urandom);
            end
            run(m);
            total++;
            if (res.size() != exq.size()) begin
                bad++; $display("FAIL rand_count[%0d] got=%0d want=%0d", m, res.size(), exq.size());
            end
            foreach (exq[j]) begin
                if (j < res.size()) begin
                    total += 3;
                    if (res[j].waits != exq[j].waits) begin
                        bad++; $display("FAIL rand_waits[%0d/%0d] got=%0d want=%0d", m, j, res[j].waits, exq[j].waits);
                    end
                    if (res[j].resp !== exq[j].resp) begin
                        bad++; $display("FAIL rand_resp[%0d/%0d] got=%b want=%b", m, j, res[j].resp, exq[j].resp);
                    end
                    if (res[j].rdata !== exq[j].rdata) begin
                        bad++; $display("FAIL rand_rdata[%0d/%0d] got=%h want=%h", m, j, res[j].rdata, exq[j].rdata);
                    end
                    if (exq[j].waits > 0) begin
                        total++;
                        if (res[j].wresp !== exq[j].wresp) begin
                            bad++; $display("FAIL rand_wresp[%0d/%0d] got=%b want=%b", m, j, res[j].wresp, exq[j].wresp);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_forward();
        push(1'b1, 12'h010, 3'd2, T_NSEQ, B_SINGLE, 32'hDEADBEEF);
        push(1'b0, 12'h010, 3'd2, T_NSEQ, B_SINGLE, 32'h0);
        run(0);
        total += 3;
        if (res[0].resp !== 1'b0) begin bad++; $display("FAIL fwd_wr_resp got=%b want=0", res[0].resp); end
        if (res[1].waits != 0) begin bad++; $display("FAIL fwd_rd_waits got=%0d want=0", res[1].waits); end
        if (res[1].rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fwd_rdata got=%h want=deadbeef", res[1].rdata); end
    endtask

    task automatic test_byte_lanes();
        push(1'b1, 12'h020, 3'd2, T_NSEQ, B_SINGLE, 32'h11223344);
        push(1'b1, 12'h021, 3'd0, T_NSEQ, B_SINGLE, 32'h0000AA00);
        push(1'b0, 12'h020, 3'd2, T_NSEQ, B_SINGLE, 32'h0);
        push(1'b1, 12'h022, 3'd1, T_NSEQ, B_SINGLE, 32'hBEEF0000);
        push(1'b0, 12'h020, 3'd2, T_NSEQ, B_SINGLE, 32'h0);
        run(0);
        total += 3;
        if (res[1].resp !== 1'b0) begin bad++; $display("FAIL byte_wr_resp got=%b want=0", res[1].resp); end
        if (res[2].rdata !== 32'h1122AA44) begin bad++; $display("FAIL byte_rdata got=%h want=1122aa44", res[2].rdata); end
        if (res[4].rdata !== 32'hBEEFAA44) begin bad++; $display("FAIL half_rdata got=%h want=beefaa44", res[4].rdata); end
    endtask

    task automatic test_wait_states();
        push(1'b1, 12'h030, 3'd2, T_NSEQ, B_SINGLE, 32'h5A5A0001);
        push(1'b0, 12'h030, 3'd2, T_NSEQ, B_SINGLE, 32'h0);
        run(1);
        total += 5;
        if (res[0].waits != 2) begin bad++; $display("FAIL ws_wr_waits got=%0d want=2", res[0].waits); end
        if (res[1].waits != 2) begin bad++; $display("FAIL ws_rd_waits got=%0d want=2", res[1].waits); end
        if (res[1].wresp !== 1'b0) begin bad++; $display("FAIL ws_wait_resp got=%b want=0", res[1].wresp); end
        if (res[1].resp !== 1'b0) begin bad++; $display("FAIL ws_rd_resp got=%b want=0", res[1].resp); end
        if (res[1].rdata !== 32'h5A5A0001) begin bad++; $display("FAIL ws_rdata got=%h want=5a5a0001", res[1].rdata); end
    endtask

    task automatic test_errors();
        push(1'b1, 12'h000, 3'd2, T_NSEQ, B_SINGLE, 32'hCAFEF00D);
        push(1'b0, 12'h000, 3'd2, T_NSEQ, B_SINGLE, 32'h0);
        push(1'b0, 12'h400, 3'd2, T_NSEQ, B_SINGLE, 32'h0);
        push(1'b1, 12'h002, 3'd2, T_NSEQ, B_SINGLE, 32'h12345678);
        push(1'b0, 12'h000, 3'd2, T_NSEQ, B_SINGLE, 32'h0);
        run(0);
        total += 10;
        if (res[1].rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL err_pre_rdata got=%h want=cafef00d", res[1].rdata); end
        for (int j = 2; j < 4; j++) begin
            if (res[j].waits != 1) begin bad++; $display("FAIL err_waits[%0d] got=%0d want=1", j, res[j].waits); end
            if (res[j].wresp !== 1'b1) begin bad++; $display("FAIL err_first_resp[%0d] got=%b want=1", j, res[j].wresp); end
            if (res[j].resp !== 1'b1) begin bad++; $display("FAIL err_resp[%0d] got=%b want=1", j, res[j].resp); end
        end
        if (res[2].rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL err_rdata_hold got=%h want=cafef00d", res[2].rdata); end
        if (res[4].resp !== 1'b0) begin bad++; $display("FAIL err_post_resp got=%b want=0", res[4].resp); end
        if (res[4].rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL err_mem_kept got=%h want=cafef00d", res[4].rdata); end
    endtask

    task automatic test_burst_reset();
        logic [31:0] wd [4];
        for (int k = 0; k < 4; k++) begin
            wd[k] = $urandom;
            push(1'b1, 12'(k * 4), 3'd2, (k == 0) ? T_NSEQ : T_SEQ, B_INCR4, wd[k]);
        end
        for (int k = 0; k < 4; k++)
            push(1'b0, 12'(k * 4), 3'd2, (k == 0) ? T_NSEQ : T_SEQ, B_INCR4, 32'h0);
        run(0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (res[4 + k].rdata !== wd[k]) begin
                bad++; $display("FAIL burst_rdata[%0d] got=%h want=%h", k, res[4 + k].rdata, wd[k]);
            end
        end
        // second INCR4 write burst, reset lands in the first beat's data phase
        hsel0 = 1'b1; haddr = 12'h000; hwrite = 1'b1; hsize = 3'd2; hburst = B_INCR4; htrans = T_NSEQ;
        @(posedge hclk); #1;
        haddr = 12'h004; htrans = T_SEQ; hwdata = ~wd[0];
        @(negedge hclk);
        hresetn = 1'b0;
        #1;
        total += 3;
        if (hreadyout0 !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", hreadyout0); end
        if (hresp0 !== 1'b0) begin bad++; $display("FAIL rst_mid_resp got=%b want=0", hresp0); end
        if (hrdata0 !== 32'h0) begin bad++; $display("FAIL rst_mid_rdata got=%h want=0", hrdata0); end
        @(posedge hclk); #1;
        hsel0 = 1'b0; htrans = T_IDLE; hresetn = 1'b1;
        push(1'b0, 12'h000, 3'd2, T_NSEQ, B_SINGLE, 32'h0);
        push(1'b0, 12'h004, 3'd2, T_NSEQ, B_SINGLE, 32'h0);
        run(0);
        total += 3;
        if (res[0].waits != 0) begin bad++; $display("FAIL rst_post_waits got=%0d want=0", res[0].waits); end
        if (res[0].rdata !== wd[0]) begin bad++; $display("FAIL rst_beat_dropped got=%h want=%h", res[0].rdata, wd[0]); end
        if (res[1].rdata !== wd[1]) begin bad++; $display("FAIL rst_next_word got=%h want=%h", res[1].rdata, wd[1]); end
    endtask

    initial begin
        test_reset();
        test_random();
        test_forward();
        test_byte_lanes();
        test_wait_states();
        test_errors();
        test_burst_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
